clip_memory_arbiter: RTL and testbench

Shares one single-port block RAM between the record path (deserializer words in) and the play path (serializer word requests out), so one clip can be recorded while the other plays. The RAM holds two clips; the clip number is the address MSB. The block tracks per-clip recorded length, sequences record and play addresses, and round-robins RAM access when both paths request in the same cycle. It sits between the top-level controller, the deserializer, the serializer and the RAM.

---
 rtl/audio_pkg.sv | 8 +
 rtl/rr_arbiter_2.sv | 15 +
 rtl/clip_memory_arbiter.sv | 177 +++++++++++++++++
 tb/tb_clip_memory_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: default widths and the state/grant encodings shared by the clip memory arbiter.
package audio_pkg;
   localparam int DEFAULT_WORD_LENGTH        = 16;
   localparam int DEFAULT_CLIP_ADDRESS_WIDTH = 16;
   typedef enum logic [1:0] {REC_IDLE, REC_ACTIVE, REC_DRAIN} rec_state_t;
   typedef enum logic {PLAY_IDLE, PLAY_ACTIVE} play_state_t;
   typedef enum logic [1:0] {GRANT_NONE, GRANT_WRITE, GRANT_READ} grant_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-requester round-robin arbiter; bit 0 is favoured first after reset,
// and the priority flips only when both requesters compete.
module rr_arbiter_2 (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   logic r_prio_hi;
   assign o_gnt = (i_req == 2'b11) ? (r_prio_hi ? 2'b10 : 2'b01) : i_req;
   always_ff @(posedge i_clock) begin
      if (i_reset) r_prio_hi <= 1'b0;
      else if (i_req == 2'b11) r_prio_hi <= ~r_prio_hi;
   end
endmodule

// File: rtl/clip_memory_arbiter.sv
// clip_memory_arbiter: shares one single-port RAM holding two clips between a record path
// and a play path, tracking per-clip lengths and arbitrating one RAM access per cycle.
module clip_memory_arbiter
   import audio_pkg::*;
#(
   parameter int WORD_LENGTH        = DEFAULT_WORD_LENGTH,
   parameter int CLIP_ADDRESS_WIDTH = DEFAULT_CLIP_ADDRESS_WIDTH
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic                        rec_start_i,
   input  logic                        rec_stop_i,
   input  logic                        rec_clip_i,
   input  logic                        rec_valid_i,
   input  logic [WORD_LENGTH-1:0]      rec_data_i,
   output logic                        recording_o,
   output logic                        rec_done_o,
   output logic                        rec_overrun_o,
   input  logic                        play_start_i,
   input  logic                        play_stop_i,
   input  logic                        play_clip_i,
   input  logic                        play_req_i,
   output logic [WORD_LENGTH-1:0]      play_data_o,
   output logic                        play_valid_o,
   output logic                        playing_o,
   output logic                        play_done_o,
   output logic                        start_reject_o,
   output logic                        mem_en_o,
   output logic                        mem_we_o,
   output logic [CLIP_ADDRESS_WIDTH:0] mem_addr_o,
   output logic [WORD_LENGTH-1:0]      mem_wdata_o,
   input  logic [WORD_LENGTH-1:0]      mem_rdata_i
);
   localparam int AW = CLIP_ADDRESS_WIDTH;
   localparam logic [AW:0] LAST_OFF = {1'b0, {AW{1'b1}}};

   rec_state_t             r_rec_state;
   play_state_t            r_play_state;
   logic                   r_rec_clip, r_play_clip;
   logic [AW:0]            r_wr_off, r_rd_off;
   logic [AW:0]            r_len [2];
   logic                   r_wr_pend, r_rd_pend, r_rd_fly, r_rd_last;
   logic [WORD_LENGTH-1:0] r_wr_data, r_play_data;
   logic                   r_rec_done, r_rec_overrun, r_play_valid, r_play_done, r_start_reject;
   logic [1:0]             w_gnt;
   grant_t                 w_grant;
   logic                   w_rec_ok, w_play_ok, w_req_ok;
   logic [AW:0]            w_rd_len;

   rr_arbiter_2 u_arb (
      .i_clock (clock_i),
      .i_reset (reset_i),
      .i_req   ({r_rd_pend, r_wr_pend}),
      .o_gnt   (w_gnt)
   );

   assign w_grant = w_gnt[0] ? GRANT_WRITE : w_gnt[1] ? GRANT_READ : GRANT_NONE;
   assign w_rd_len = r_len[r_play_clip];
   assign w_rec_ok = rec_start_i && r_rec_state == REC_IDLE &&
                     !(r_play_state == PLAY_ACTIVE && rec_clip_i == r_play_clip);
   // A same-cycle record start on the same clip takes precedence over the play start.
   assign w_play_ok = play_start_i && r_play_state == PLAY_IDLE &&
                      !(r_rec_state != REC_IDLE && play_clip_i == r_rec_clip) &&
                      !(w_rec_ok && play_clip_i == rec_clip_i);
   assign w_req_ok = play_req_i && r_play_state == PLAY_ACTIVE && !r_rd_pend && !r_rd_fly &&
                     r_rd_off != w_rd_len;

   assign mem_en_o    = w_grant != GRANT_NONE;
   assign mem_we_o    = w_grant == GRANT_WRITE;
   assign mem_addr_o  = (w_grant == GRANT_WRITE) ? {r_rec_clip, r_wr_off[AW-1:0]} :
                        (w_grant == GRANT_READ)  ? {r_play_clip, r_rd_off[AW-1:0]} : '0;
   assign mem_wdata_o = (w_grant == GRANT_WRITE) ? r_wr_data : '0;

   assign recording_o    = r_rec_state != REC_IDLE;
   assign playing_o      = r_play_state == PLAY_ACTIVE;
   assign rec_done_o     = r_rec_done;
   assign rec_overrun_o  = r_rec_overrun;
   assign play_data_o    = r_play_data;
   assign play_valid_o   = r_play_valid;
   assign play_done_o    = r_play_done;
   assign start_reject_o = r_start_reject;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_rec_state   <= REC_IDLE;
         r_rec_clip    <= 1'b0;
         r_wr_off      <= '0;
         r_wr_pend     <= 1'b0;
         r_wr_data     <= '0;
         r_len[0]      <= '0;
         r_len[1]      <= '0;
         r_rec_done    <= 1'b0;
         r_rec_overrun <= 1'b0;
      end else begin
         r_rec_done    <= 1'b0;
         r_rec_overrun <= 1'b0;
         if (w_grant == GRANT_WRITE) begin
            r_wr_pend <= 1'b0;
            r_wr_off  <= r_wr_off + 1'b1;
         end
         case (r_rec_state)
            REC_IDLE: if (w_rec_ok) begin
               r_rec_state <= REC_ACTIVE;
               r_rec_clip  <= rec_clip_i;
               r_wr_off    <= '0;
               r_wr_pend   <= 1'b0;
            end
            REC_ACTIVE: begin
               if (rec_valid_i && r_wr_pend) r_rec_overrun <= 1'b1;
               else if (rec_valid_i) begin
                  r_wr_data <= rec_data_i;
                  r_wr_pend <= 1'b1;
               end
               // The last offset of the clip auto-stops so the offset can never wrap.
               if (rec_stop_i || (w_grant == GRANT_WRITE && r_wr_off == LAST_OFF))
                  r_rec_state <= REC_DRAIN;
            end
            REC_DRAIN: if (!r_wr_pend) begin
               r_len[r_rec_clip] <= r_wr_off;
               r_rec_done        <= 1'b1;
               r_rec_state       <= REC_IDLE;
            end
            default: r_rec_state <= REC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_play_state   <= PLAY_IDLE;
         r_play_clip    <= 1'b0;
         r_rd_off       <= '0;
         r_rd_pend      <= 1'b0;
         r_rd_fly       <= 1'b0;
         r_rd_last      <= 1'b0;
         r_play_data    <= '0;
         r_play_valid   <= 1'b0;
         r_play_done    <= 1'b0;
         r_start_reject <= 1'b0;
      end else begin
         r_play_valid   <= 1'b0;
         r_play_done    <= 1'b0;
         r_start_reject <= (rec_start_i && !w_rec_ok) || (play_start_i && !w_play_ok);
         r_rd_fly       <= w_grant == GRANT_READ;
         if (w_grant == GRANT_READ) begin
            r_rd_pend <= 1'b0;
            r_rd_off  <= r_rd_off + 1'b1;
            r_rd_last <= r_rd_off == w_rd_len - 1'b1;
         end
         if (r_play_state == PLAY_IDLE) begin
            if (w_play_ok) begin
               r_play_clip <= play_clip_i;
               r_rd_off    <= '0;
               r_rd_pend   <= 1'b0;
               if (r_len[play_clip_i] == '0) r_play_done <= 1'b1;
               else r_play_state <= PLAY_ACTIVE;
            end
         end else if (play_stop_i) begin
            r_play_state <= PLAY_IDLE;
            r_rd_pend    <= 1'b0;
            r_rd_fly     <= 1'b0;
            r_play_done  <= 1'b1;
         end else begin
            if (w_req_ok) r_rd_pend <= 1'b1;
            // RAM data arrives the cycle after the grant and is registered here.
            if (r_rd_fly) begin
               r_play_valid <= 1'b1;
               r_play_data  <= mem_rdata_i;
               if (r_rd_last) begin
                  r_play_done  <= 1'b1;
                  r_play_state <= PLAY_IDLE;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_clip_memory_arbiter.sv
// tb_clip_memory_arbiter: scenario bench with a RAM model; expected play words are queued
// at request time and compared against the words the DUT delivers.
module tb_clip_memory_arbiter;
   localparam int WL = 16;
   localparam int AW = 3;

   logic          clk = 1'b0, rst = 1'b1;
   logic          rec_start = 1'b0, rec_stop = 1'b0, rec_clip = 1'b0, rec_valid = 1'b0;
   logic [WL-1:0] rec_data = '0;
   logic          play_start = 1'b0, play_stop = 1'b0, play_clip = 1'b0, play_req = 1'b0;
   logic          recording, rec_done, rec_overrun, play_valid, playing, play_done, start_reject;
   logic          mem_en, mem_we;
   logic [WL-1:0] play_data, mem_wdata, mem_rdata;
   logic [AW:0]   mem_addr;
   logic [WL-1:0] mem [16];

   int            cyc = 0, n_tests = 0, n_fail = 0, obs_idx = 0;
   int            n_rec_done = 0, n_play_done = 0, n_overrun = 0;
   int            grant_cyc[$], obs_lat[$];
   logic [WL-1:0] obs_data[$], exp_data[$];
   logic          obs_done[$], exp_done[$];

   clip_memory_arbiter #(.WORD_LENGTH(WL), .CLIP_ADDRESS_WIDTH(AW)) dut (
      .clock_i(clk), .reset_i(rst),
      .rec_start_i(rec_start), .rec_stop_i(rec_stop), .rec_clip_i(rec_clip),
      .rec_valid_i(rec_valid), .rec_data_i(rec_data),
      .recording_o(recording), .rec_done_o(rec_done), .rec_overrun_o(rec_overrun),
      .play_start_i(play_start), .play_stop_i(play_stop), .play_clip_i(play_clip),
      .play_req_i(play_req), .play_data_o(play_data), .play_valid_o(play_valid),
      .playing_o(playing), .play_done_o(play_done), .start_reject_o(start_reject),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   // Observer only: records read grants, delivered words and pulse counts.
   always @(negedge clk) begin
      if (rst) grant_cyc.delete();
      else if (mem_en && !mem_we) grant_cyc.push_back(cyc);
      if (play_valid) begin
         obs_data.push_back(play_data);
         obs_done.push_back(play_done);
         if (grant_cyc.size() != 0) obs_lat.push_back(cyc - grant_cyc.pop_front());
         else obs_lat.push_back(-1);
      end
      if (rec_done) n_rec_done++;
      if (play_done) n_play_done++;
      if (rec_overrun) n_overrun++;
   end

   task automatic step(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; step(3); rst = 1'b0; step();
      n_tests++;
      if ({recording, playing, rec_done, rec_overrun, play_valid, play_done, start_reject, mem_en} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_flags got=%b exp=%b", {recording, playing, rec_done, rec_overrun,
                  play_valid, play_done, start_reject, mem_en}, 8'b0);
      end
      n_tests++;
      if (play_data !== '0) begin n_fail++; $display("FAIL reset_play_data got=%h exp=0000", play_data); end
   endtask

   task automatic test_record();
      int r0 = n_rec_done;
      int o0 = n_overrun;
      rec_clip = 1'b0; rec_start = 1'b1; step(); rec_start = 1'b0;
      n_tests++;
      if (recording !== 1'b1) begin n_fail++; $display("FAIL rec_start got=%b exp=1", recording); end
      for (int i = 0; i < 5; i++) begin
         rec_valid = 1'b1; rec_data = 16'((i + 1) * 'h11); step(); rec_valid = 1'b0; step(2);
      end
      rec_stop = 1'b1; step(); rec_stop = 1'b0; step(4);
      n_tests++;
      if (n_rec_done - r0 != 1 || recording !== 1'b0 || n_overrun != o0) begin
         n_fail++;
         $display("FAIL rec_done got done=%0d rec=%b ovr=%0d exp done=1 rec=0 ovr=0",
                  n_rec_done - r0, recording, n_overrun - o0);
      end
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (mem[i] !== 16'((i + 1) * 'h11)) begin
            n_fail++; $display("FAIL rec_mem[%0d] got=%h exp=%h", i, mem[i], 16'((i + 1) * 'h11));
         end
      end
   endtask

   task automatic test_play();
      int p0 = n_play_done;
      play_clip = 1'b0; play_start = 1'b1; step(); play_start = 1'b0;
      n_tests++;
      if (playing !== 1'b1) begin n_fail++; $display("FAIL play_start got=%b exp=1", playing); end
      for (int i = 0; i < 5; i++) begin
         exp_data.push_back(16'((i + 1) * 'h11)); exp_done.push_back(i == 4);
         play_req = 1'b1; step(); play_req = 1'b0; step(9);
      end
      while (exp_data.size() != 0) begin
         n_tests++;
         if (obs_idx >= obs_data.size()) begin n_fail++; $display("FAIL play_word missing exp=%h", exp_data[0]); end
         else if (obs_data[obs_idx] !== exp_data[0] || obs_done[obs_idx] !== exp_done[0] || obs_lat[obs_idx] != 2) begin
            n_fail++;
            $display("FAIL play_word got data=%h done=%b lat=%0d exp data=%h done=%b lat=2",
                     obs_data[obs_idx], obs_done[obs_idx], obs_lat[obs_idx], exp_data[0], exp_done[0]);
         end
         obs_idx++; void'(exp_data.pop_front()); void'(exp_done.pop_front());
      end
      n_tests++;
      if (obs_idx != obs_data.size()) begin n_fail++; $display("FAIL play_count got=%0d exp=%0d", obs_data.size(), obs_idx); end
      obs_idx = obs_data.size();
      n_tests++;
      if (playing !== 1'b0 || n_play_done - p0 != 1) begin
         n_fail++; $display("FAIL play_end got playing=%b done=%0d exp playing=0 done=1", playing, n_play_done - p0);
      end
   endtask

   task automatic test_back_to_back();
      int r0 = n_rec_done;
      int p0 = n_play_done;
      rec_clip = 1'b1; rec_start = 1'b1; play_clip = 1'b0; play_start = 1'b1; step();
      rec_start = 1'b0; play_start = 1'b0;
      n_tests++;
      if ({recording, playing} !== 2'b11) begin n_fail++; $display("FAIL concurrent_start got=%b exp=11", {recording, playing}); end
      rec_valid = 1'b1; rec_data = 16'h00A1; play_req = 1'b1;
      exp_data.push_back(16'h0011); exp_done.push_back(1'b0);
      step(); rec_valid = 1'b0; play_req = 1'b0;
      n_tests++;
      if ({mem_en, mem_we, mem_addr} !== {2'b11, 4'd8}) begin n_fail++; $display("FAIL contend1_first got=%b exp=%b", {mem_en, mem_we, mem_addr}, {2'b11, 4'd8}); end
      step();
      n_tests++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 4'd0}) begin n_fail++; $display("FAIL contend1_second got=%b exp=%b", {mem_en, mem_we, mem_addr}, {2'b10, 4'd0}); end
      step(6);
      rec_valid = 1'b1; rec_data = 16'h00A2; play_req = 1'b1;
      exp_data.push_back(16'h0022); exp_done.push_back(1'b0);
      step(); rec_valid = 1'b0; play_req = 1'b0;
      n_tests++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 4'd1}) begin n_fail++; $display("FAIL contend2_first got=%b exp=%b", {mem_en, mem_we, mem_addr}, {2'b10, 4'd1}); end
      step();
      n_tests++;
      if ({mem_en, mem_we, mem_addr} !== {2'b11, 4'd9}) begin n_fail++; $display("FAIL contend2_second got=%b exp=%b", {mem_en, mem_we, mem_addr}, {2'b11, 4'd9}); end
      step(6);
      while (exp_data.size() != 0) begin
         n_tests++;
         if (obs_idx >= obs_data.size()) begin n_fail++; $display("FAIL concurrent_word missing exp=%h", exp_data[0]); end
         else if (obs_data[obs_idx] !== exp_data[0] || obs_done[obs_idx] !== exp_done[0] || obs_lat[obs_idx] != 2) begin
            n_fail++;
            $display("FAIL concurrent_word got data=%h done=%b lat=%0d exp data=%h done=%b lat=2",
                     obs_data[obs_idx], obs_done[obs_idx], obs_lat[obs_idx], exp_data[0], exp_done[0]);
         end
         obs_idx++; void'(exp_data.pop_front()); void'(exp_done.pop_front());
      end
      rec_stop = 1'b1; play_stop = 1'b1; step(); rec_stop = 1'b0; play_stop = 1'b0; step(4);
      n_tests++;
      if (obs_idx != obs_data.size()) begin n_fail++; $display("FAIL concurrent_count got=%0d exp=%0d", obs_data.size(), obs_idx); end
      obs_idx = obs_data.size();
      n_tests++;
      if (n_rec_done - r0 != 1 || n_play_done - p0 != 1 || {recording, playing} !== 2'b00) begin
         n_fail++;
         $display("FAIL concurrent_stop got rdone=%0d pdone=%0d flags=%b exp 1 1 00",
                  n_rec_done - r0, n_play_done - p0, {recording, playing});
      end
      n_tests++;
      if (mem[8] !== 16'h00A1 || mem[9] !== 16'h00A2) begin
         n_fail++; $display("FAIL concurrent_mem got=%h,%h exp=00a1,00a2", mem[8], mem[9]);
      end
   endtask

   task automatic test_conflict();
      play_clip = 1'b1; play_start = 1'b1; step(); play_start = 1'b0;
      rec_clip = 1'b1; rec_start = 1'b1; step(); rec_start = 1'b0;
      n_tests++;
      if ({start_reject, recording, playing} !== 3'b101) begin
         n_fail++; $display("FAIL conflict_rec got rej/rec/play=%b exp=101", {start_reject, recording, playing});
      end
      play_stop = 1'b1; step(); play_stop = 1'b0; step();
      rec_clip = 1'b0; play_clip = 1'b0; rec_start = 1'b1; play_start = 1'b1; step();
      rec_start = 1'b0; play_start = 1'b0;
      n_tests++;
      if ({start_reject, recording, playing} !== 3'b110) begin
         n_fail++; $display("FAIL conflict_same_clip got rej/rec/play=%b exp=110", {start_reject, recording, playing});
      end
      rec_stop = 1'b1; step(); rec_stop = 1'b0; step(3);
      n_tests++;
      if (recording !== 1'b0) begin n_fail++; $display("FAIL conflict_stop got=%b exp=0", recording); end
   endtask

   task automatic test_overrun_autostop();
      int r0 = n_rec_done;
      int o0 = n_overrun;
      int p0 = n_play_done;
      rec_clip = 1'b0; rec_start = 1'b1; play_clip = 1'b1; play_start = 1'b1; step();
      rec_start = 1'b0; play_start = 1'b0;
      play_req = 1'b1; exp_data.push_back(16'h00A1); exp_done.push_back(1'b0); step(); play_req = 1'b0;
      rec_valid = 1'b1; rec_data = 16'h0100; step();
      rec_data = 16'hDEAD; step(); rec_valid = 1'b0; step(2);
      n_tests++;
      if (n_overrun - o0 != 1) begin n_fail++; $display("FAIL overrun_count got=%0d exp=1", n_overrun - o0); end
      for (int i = 1; i < 8; i++) begin
         rec_valid = 1'b1; rec_data = 16'(16'h0100 + i); step(); rec_valid = 1'b0; step(2);
      end
      step(3);
      n_tests++;
      if (n_rec_done - r0 != 1 || recording !== 1'b0) begin
         n_fail++; $display("FAIL autostop got done=%0d rec=%b exp done=1 rec=0", n_rec_done - r0, recording);
      end
      rec_valid = 1'b1; rec_data = 16'hBEEF; step(); rec_valid = 1'b0; step(2);
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (mem[i] !== 16'(16'h0100 + i)) begin n_fail++; $display("FAIL autostop_mem[%0d] got=%h exp=%h", i, mem[i], 16'(16'h0100 + i)); end
      end
      play_stop = 1'b1; step(); play_stop = 1'b0; step();
      n_tests++;
      if (playing !== 1'b0 || n_play_done - p0 != 1) begin
         n_fail++; $display("FAIL play_stop got playing=%b done=%0d exp 0 1", playing, n_play_done - p0);
      end
      play_clip = 1'b0; play_start = 1'b1; step(); play_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_data.push_back(16'(16'h0100 + i)); exp_done.push_back(i == 7);
         play_req = 1'b1; step(); play_req = 1'b0; step(4);
      end
      play_req = 1'b1; step(); play_req = 1'b0; step(4);
      while (exp_data.size() != 0) begin
         n_tests++;
         if (obs_idx >= obs_data.size()) begin n_fail++; $display("FAIL full_clip_word missing exp=%h", exp_data[0]); end
         else if (obs_data[obs_idx] !== exp_data[0] || obs_done[obs_idx] !== exp_done[0] || obs_lat[obs_idx] != 2) begin
            n_fail++;
            $display("FAIL full_clip_word got data=%h done=%b lat=%0d exp data=%h done=%b lat=2",
                     obs_data[obs_idx], obs_done[obs_idx], obs_lat[obs_idx], exp_data[0], exp_done[0]);
         end
         obs_idx++; void'(exp_data.pop_front()); void'(exp_done.pop_front());
      end
      n_tests++;
      if (obs_idx != obs_data.size() || playing !== 1'b0) begin
         n_fail++; $display("FAIL full_clip_end got valids=%0d playing=%b exp valids=%0d playing=0", obs_data.size(), playing, obs_idx);
      end
      obs_idx = obs_data.size();
   endtask

   task automatic test_reset_mid_play();
      int p0 = n_play_done;
      int v0 = obs_data.size();
      play_clip = 1'b0; play_start = 1'b1; step(); play_start = 1'b0;
      play_req = 1'b1; step(); play_req = 1'b0;
      n_tests++;
      if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL midplay_grant got=%b exp=10", {mem_en, mem_we}); end
      step(); rst = 1'b1; step(2); rst = 1'b0;
      n_tests++;
      if ({playing, play_valid, play_done} !== 3'b000) begin
         n_fail++; $display("FAIL midplay_reset got play/valid/done=%b exp=000", {playing, play_valid, play_done});
      end
      step(3);
      n_tests++;
      if (obs_data.size() != v0 || n_play_done != p0) begin
         n_fail++; $display("FAIL midplay_quiet got valids=%0d dones=%0d exp 0 0", obs_data.size() - v0, n_play_done - p0);
      end
      obs_idx = obs_data.size();
      for (int c = 0; c < 2; c++) begin
         play_clip = c[0]; play_start = 1'b1; step(); play_start = 1'b0;
         n_tests++;
         if ({playing, play_done, start_reject} !== 3'b010) begin
            n_fail++; $display("FAIL len_zero_clip%0d got play/done/rej=%b exp=010", c, {playing, play_done, start_reject});
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_record();
      test_play();
      test_back_to_back();
      test_conflict();
      test_overrun_autostop();
      test_reset_mid_play();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
